// File: rtl/dma_result_writeback.sv
// Result write-back stage: adds bias, rescales and saturates Q32.32 results to Q16.16,
// buffers them in a FIFO and drains them to SDRAM in bursts under CPU register control.
module dma_result_writeback #(
  parameter int FIFO_DEPTH  = 64,
  parameter int BURST_WORDS = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        reg_valid,
  input  logic        reg_write,
  input  logic [7:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  output logic        reg_ready,
  input  logic        res_valid,
  input  logic [63:0] res_data,
  output logic        res_ready,
  output logic        burst_wr,
  output logic [24:0] burst_addr,
  output logic [10:0] burst_len,
  output logic        burst_32bit,
  output logic [31:0] burst_wr_data,
  input  logic        burst_data_req,
  input  logic        burst_data_done
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int NW = $clog2(BURST_WORDS + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] BURST_C = CW'(BURST_WORDS);

  typedef enum logic [2:0] {IDLE, COLLECT, ISSUE, WRITE, DONE} state_t;
  state_t state_reg, state_next;

  logic              access_done_reg, busy_reg, sat_flag_reg, relu_en_reg;
  logic [9:0]        count_reg, written_reg, rem_in_reg, rem_out_reg;
  logic [23:0]       dst_addr_reg, wptr_reg;
  logic [31:0]       bias_reg;
  logic [5:0]        shift_reg;
  logic [NW-1:0]     burst_n_reg, n_issue;
  logic              s1_valid_reg, s2_valid_reg;
  logic signed [64:0] s1_sum_reg, shifted;
  logic [31:0]       s2_data_reg, s2_value;
  logic              clip;
  logic [31:0]       fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]     fifo_count_reg;

  logic [5:0] reg_idx;
  logic wr_fire, cfg_wr, start_fire, accept, push, pop, pipe_empty, done_evt, fifo_empty;
  logic unused_addr;

  assign reg_idx     = reg_addr[7:2];
  assign unused_addr = ^reg_addr[1:0];
  assign wr_fire     = reg_valid && reg_write && !access_done_reg;
  assign cfg_wr      = wr_fire && !busy_reg;
  assign start_fire  = cfg_wr && (reg_idx == 6'd0) && reg_wdata[0];
  assign accept      = res_valid && res_ready;
  assign push        = s2_valid_reg;
  assign pop         = burst_data_req && (fifo_count_reg != '0);
  assign pipe_empty  = !s1_valid_reg && !s2_valid_reg;
  assign done_evt    = (state_reg == WRITE) && burst_data_done;
  assign fifo_empty  = (fifo_count_reg == '0);
  assign reg_ready   = reg_valid;
  assign burst_32bit = 1'b1;

  // Admission counts results still in the pipeline so the FIFO can never overflow.
  assign res_ready = busy_reg && (rem_in_reg != '0) &&
                     ((fifo_count_reg + CW'(s1_valid_reg) + CW'(s2_valid_reg)) < DEPTH_C);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      access_done_reg <= 1'b0;
      busy_reg        <= 1'b0;
      sat_flag_reg    <= 1'b0;
      relu_en_reg     <= 1'b0;
      count_reg       <= '0;
      written_reg     <= '0;
      rem_in_reg      <= '0;
      rem_out_reg     <= '0;
      dst_addr_reg    <= '0;
      wptr_reg        <= '0;
      bias_reg        <= '0;
      shift_reg       <= 6'd16;
      burst_n_reg     <= '0;
    end else begin
      access_done_reg <= reg_valid;
      if (cfg_wr) begin
        case (reg_idx)
          6'd1: count_reg    <= reg_wdata[9:0];
          6'd2: dst_addr_reg <= reg_wdata[23:0];
          6'd3: bias_reg     <= reg_wdata;
          6'd4: begin
            shift_reg   <= reg_wdata[5:0];
            relu_en_reg <= reg_wdata[8];
          end
          default: ;
        endcase
      end
      if (start_fire)               busy_reg <= 1'b1;
      else if (state_reg == DONE)   busy_reg <= 1'b0;
      if (start_fire)               rem_in_reg <= count_reg;
      else if (accept)              rem_in_reg <= rem_in_reg - 10'd1;
      if (start_fire) begin
        rem_out_reg <= count_reg;
        wptr_reg    <= dst_addr_reg;
        written_reg <= '0;
      end else if (done_evt) begin
        wptr_reg    <= wptr_reg + 24'(burst_n_reg);
        written_reg <= written_reg + 10'(burst_n_reg);
        rem_out_reg <= rem_out_reg - 10'(burst_n_reg);
      end
      if (state_reg == ISSUE)       burst_n_reg <= n_issue;
      if (start_fire)               sat_flag_reg <= 1'b0;
      else if (s1_valid_reg && clip) sat_flag_reg <= 1'b1;
    end
  end

  // Stage 2: rescale, optional ReLU, then clamp to the signed 32-bit range.
  always_comb begin
    shifted = s1_sum_reg >>> shift_reg;
    clip    = 1'b0;
    if (relu_en_reg && shifted[64]) shifted = '0;
    if (shifted[64:31] != {34{shifted[64]}}) begin
      clip     = 1'b1;
      s2_value = shifted[64] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      s2_value = shifted[31:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
      s1_sum_reg   <= '0;
      s2_data_reg  <= '0;
    end else begin
      s1_valid_reg <= accept;
      s2_valid_reg <= s1_valid_reg;
      s1_sum_reg   <= $signed({res_data[63], res_data}) +
                      $signed({{17{bias_reg[31]}}, bias_reg, 16'h0000});
      s2_data_reg  <= s2_value;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= s2_data_reg;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fifo_count_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count_reg <= fifo_count_reg + 1'b1;
        2'b01:   fifo_count_reg <= fifo_count_reg - 1'b1;
        default: fifo_count_reg <= fifo_count_reg;
      endcase
    end
  end

  assign burst_wr_data = fifo_empty ? 32'h0 : fifo_mem[rd_ptr_reg];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_fire) state_next = (count_reg == '0) ? DONE : COLLECT;
      COLLECT: if ((fifo_count_reg >= BURST_C) ||
                   ((rem_in_reg == '0) && pipe_empty && !fifo_empty)) state_next = ISSUE;
      ISSUE:   state_next = WRITE;
      WRITE:   if (burst_data_done)
                 state_next = (rem_out_reg == 10'(burst_n_reg)) ? DONE : COLLECT;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    burst_wr   = 1'b0;
    burst_addr = '0;
    burst_len  = '0;
    n_issue    = (fifo_count_reg >= BURST_C) ? NW'(BURST_WORDS) : fifo_count_reg[NW-1:0];
    if (state_reg == ISSUE) begin
      burst_wr   = 1'b1;
      burst_addr = {wptr_reg, 1'b0};
      burst_len  = 11'({n_issue, 1'b0});
    end
  end

  always_comb begin
    reg_rdata = '0;
    if (reg_valid) begin
      case (reg_idx)
        6'd0: reg_rdata = {29'b0, sat_flag_reg, fifo_empty, busy_reg};
        6'd1: reg_rdata = {22'b0, count_reg};
        6'd2: reg_rdata = {8'b0, dst_addr_reg};
        6'd3: reg_rdata = bias_reg;
        6'd4: reg_rdata = {23'b0, relu_en_reg, 2'b0, shift_reg};
        6'd5: reg_rdata = {22'b0, written_reg};
        default: reg_rdata = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_dma_result_writeback.sv
// Randomized scoreboard bench for dma_result_writeback: a producer pushes expected words,
// an SDRAM-side monitor checks every burst request and every popped word.
module tb_dma_result_writeback;
  localparam int DEPTH = 64;
  localparam int BW    = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        reg_valid, reg_write;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata, reg_rdata;
  logic        reg_ready;
  logic        res_valid;
  logic [63:0] res_data;
  logic        res_ready;
  logic        burst_wr;
  logic [24:0] burst_addr;
  logic [10:0] burst_len;
  logic        burst_32bit;
  logic [31:0] burst_wr_data;
  logic        burst_data_req, burst_data_done;

  always #5 clk = ~clk;

  dma_result_writeback #(.FIFO_DEPTH(DEPTH), .BURST_WORDS(BW)) dut (
    .clk(clk), .reset_n(reset_n),
    .reg_valid(reg_valid), .reg_write(reg_write), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .reg_ready(reg_ready),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .burst_wr(burst_wr), .burst_addr(burst_addr), .burst_len(burst_len),
    .burst_32bit(burst_32bit), .burst_wr_data(burst_wr_data),
    .burst_data_req(burst_data_req), .burst_data_done(burst_data_done)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_data[$];
  logic [24:0] exp_baddr[$];
  logic [10:0] exp_blen[$];
  logic [63:0] stim_q[$];

  logic [31:0] cfg_bias;
  int          cfg_shift;
  bit          cfg_relu;
  bit          exp_sat;
  bit          sdram_en = 1'b1;
  int          stall_cycles = 0;
  int          acc_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: bias aligned to Q32.32, arithmetic rescale, ReLU, clamp to signed 32 bits.
  function automatic logic [31:0] model(input logic [63:0] r, output bit sat);
    logic signed [95:0] s, v;
    s = $signed(r);
    s = s + $signed(cfg_bias) * 96'sd65536;
    v = s >>> cfg_shift;
    sat = 1'b0;
    if (cfg_relu && v < 0) v = 0;
    if (v > 96'sd2147483647) begin
      sat = 1'b1;
      return 32'h7FFF_FFFF;
    end
    if (v < -96'sd2147483648) begin
      sat = 1'b1;
      return 32'h8000_0000;
    end
    return v[31:0];
  endfunction

  function automatic logic [63:0] rand_res();
    logic [63:0] r;
    logic [31:0] hi;
    case ($urandom_range(0, 3))
      0: r = {$urandom, $urandom};
      1: begin hi = $urandom_range(0, 4000); r = {hi, $urandom}; end
      2: begin hi = $urandom_range(0, 4000); r = -{hi, $urandom}; end
      default: begin hi = 32'h7FFF_8000 + $urandom_range(0, 65535); r = {hi, $urandom}; end
    endcase
    return r;
  endfunction

  task automatic reg_wr(input logic [7:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    reg_valid = 1'b1; reg_write = 1'b1; reg_addr = a; reg_wdata = d;
    @(posedge clk); #1;
    reg_valid = 1'b0; reg_write = 1'b0;
  endtask

  task automatic reg_rd(input logic [7:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    reg_valid = 1'b1; reg_write = 1'b0; reg_addr = a;
    @(negedge clk);
    d = reg_rdata;
    @(posedge clk); #1;
    reg_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    logic [31:0] st;
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < bound && !idle; i++) begin
      reg_rd(8'h00, st);
      idle = !st[0];
    end
    if (!idle) begin
      checks++; errors++;
      $display("FAIL busy_timeout: busy still 1 after %0d polls, expected 0", bound);
    end
  endtask

  // Producer: holds each result until accepted; expected word is queued at acceptance.
  task automatic feed(input int n, input bit dense);
    int sent, budget;
    bit fire, sat;
    logic [31:0] e;
    sent = 0; budget = 0; fire = 1'b0;
    res_valid = 1'b0;
    while (sent < n && budget < 20000) begin
      @(posedge clk); #1;
      budget++;
      if (fire) begin
        e = model(res_data, sat);
        exp_sat = exp_sat | sat;
        exp_data.push_back(e);
        sent++; acc_cnt++;
        res_valid = 1'b0;
      end
      if (sent < n && !res_valid && (dense || $urandom_range(0, 2) != 0)) begin
        res_data  = (stim_q.size() != 0) ? stim_q.pop_front() : rand_res();
        res_valid = 1'b1;
      end
      @(negedge clk);
      fire = res_valid && res_ready;
    end
    res_valid = 1'b0;
    if (sent < n) begin
      checks++; errors++;
      $display("FAIL feed_timeout: accepted %0d, expected %0d", sent, n);
    end
  endtask

  // SDRAM-side monitor: checks burst requests and every popped word against the scoreboard.
  initial begin
    int nwords, popped, guard;
    burst_data_req = 1'b0; burst_data_done = 1'b0;
    forever begin
      @(negedge clk);
      if (sdram_en && burst_wr) begin
        $display("burst addr=0x%0h len=%0d", burst_addr, burst_len);
        if (exp_baddr.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_burst: got addr 0x%0h len %0d, expected none", burst_addr, burst_len);
        end else begin
          chk("burst_addr", 64'(burst_addr), 64'(exp_baddr.pop_front()));
          chk("burst_len", 64'(burst_len), 64'(exp_blen.pop_front()));
        end
        nwords = int'(burst_len) / 2;
        if (stall_cycles > 0) begin
          repeat (stall_cycles) @(posedge clk);
          stall_cycles = 0;
          @(negedge clk);
          chk("res_ready_at_full", 64'(res_ready), 64'd0);
          chk("accepted_at_full", 64'(acc_cnt), 64'(DEPTH));
        end
        popped = 0; guard = 0;
        while (popped < nwords && guard < 5000) begin
          @(posedge clk); #1;
          burst_data_req = ($urandom_range(0, 3) != 0);
          guard++;
          @(negedge clk);
          if (burst_data_req) begin
            if (exp_data.size() == 0) begin
              checks++; errors++;
              $display("FAIL burst_data: got 0x%0h, expected no data pending", burst_wr_data);
            end else begin
              chk("burst_data", 64'(burst_wr_data), 64'(exp_data.pop_front()));
            end
            popped++;
          end
        end
        @(posedge clk); #1;
        burst_data_req = 1'b0; burst_data_done = 1'b1;
        @(posedge clk); #1;
        burst_data_done = 1'b0;
      end
    end
  end

  task automatic run_job(input string tag, input int cnt, input logic [23:0] dst,
                         input logic [31:0] bias, input int sh, input bit relu,
                         input int stall, input bit dense);
    int rem, n;
    logic [23:0] a;
    logic [31:0] v;
    cfg_bias = bias; cfg_shift = sh; cfg_relu = relu;
    exp_sat = 1'b0; acc_cnt = 0; stall_cycles = stall;
    reg_wr(8'h04, 32'(cnt));
    reg_wr(8'h08, {8'h0, dst});
    reg_wr(8'h0C, bias);
    reg_wr(8'h10, {23'b0, relu, 2'b0, 6'(sh)});
    rem = cnt; a = dst;
    while (rem > 0) begin
      n = (rem < BW) ? rem : BW;
      exp_baddr.push_back({a, 1'b0});
      exp_blen.push_back(11'(2 * n));
      a = a + 24'(n);
      rem -= n;
    end
    reg_wr(8'h00, 32'h1);
    fork
      feed(cnt, dense);
      begin
        if (stall > 0) begin
          reg_wr(8'h04, 32'h3FF);
          reg_rd(8'h04, v);
          chk("count_locked_busy", 64'(v), 64'(cnt));
          reg_wr(8'h10, 32'h0);
          reg_wr(8'h00, 32'h1);
        end
        wait_idle(5000);
      end
    join
    reg_rd(8'h14, v);
    chk({tag, "_written"}, 64'(v), 64'(cnt));
    reg_rd(8'h00, v);
    chk({tag, "_status"}, 64'(v), 64'({exp_sat, 2'b10}));
    chk({tag, "_data_left"}, 64'(exp_data.size()), 64'd0);
    chk({tag, "_bursts_left"}, 64'(exp_baddr.size()), 64'd0);
    $display("job %s count=%0d dst=0x%0h bias=0x%0h shift=%0d relu=%0d done", tag, cnt, dst, bias, sh, relu);
  endtask

  initial begin
    logic [31:0] v;
    bit seen;
    reset_n = 1'b0;
    reg_valid = 1'b0; reg_write = 1'b0; reg_addr = '0; reg_wdata = '0;
    res_valid = 1'b0; res_data = '0;
    #1;
    chk("rst_burst_wr", 64'(burst_wr), 64'd0);
    chk("rst_res_ready", 64'(res_ready), 64'd0);
    chk("rst_burst_32bit", 64'(burst_32bit), 64'd1);
    chk("rst_reg_rdata", 64'(reg_rdata), 64'd0);
    #20;
    reset_n = 1'b1;
    reg_rd(8'h10, v); chk("rst_cfg", 64'(v), 64'h10);
    reg_rd(8'h00, v); chk("rst_status", 64'(v), 64'h2);

    // Fixed examples
    for (int k = 1; k <= 4; k++) stim_q.push_back(64'(k) << 32);
    run_job("t1", 4, 24'h000100, 32'h0, 16, 1'b0, 0, 1'b0);
    run_job("t2_wrap", 40, 24'hFFFFF8, 32'h0, 16, 1'b0, 0, 1'b0);
    stim_q.push_back(64'hFFFF_FFFF_0000_0000);
    stim_q.push_back(64'h7FFF_FFFF_0000_0000);
    run_job("t3_relu_sat", 2, 24'h000200, 32'h0, 16, 1'b1, 0, 1'b0);
    stim_q.push_back(64'h0);
    run_job("t4_bias", 1, 24'h000300, 32'h0001_8000, 16, 1'b0, 0, 1'b0);
    stim_q.push_back(64'd5);
    run_job("t4_shift0", 1, 24'h000310, 32'h0, 0, 1'b0, 0, 1'b0);
    run_job("t5_full", 100, 24'h001000, 32'h0000_0100, 20, 1'b0, 300, 1'b1);
    for (int j = 0; j < 4; j++)
      run_job("rand", $urandom_range(1, 130), 24'($urandom),
              ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 1 << 20)),
              $urandom_range(0, 40), 1'($urandom_range(0, 1)), 0, 1'b0);

    // COUNT=0: busy for exactly one cycle, no burst
    reg_wr(8'h04, 32'h0);
    @(posedge clk); #1;
    reg_valid = 1'b1; reg_write = 1'b1; reg_addr = 8'h00; reg_wdata = 32'h1;
    @(posedge clk); #1;
    reg_write = 1'b0;
    @(negedge clk); chk("count0_busy_first", 64'(reg_rdata[0]), 64'd1);
    @(posedge clk); #1;
    @(negedge clk); chk("count0_busy_after", 64'(reg_rdata[0]), 64'd0);
    @(posedge clk); #1; reg_valid = 1'b0;
    repeat (5) @(posedge clk);
    $display("job count0 done");

    // Reset in the middle of a write burst
    sdram_en = 1'b0;
    cfg_bias = 32'h0; cfg_shift = 16; cfg_relu = 1'b0; exp_sat = 1'b0;
    reg_wr(8'h04, 32'd4);
    reg_wr(8'h10, 32'd16);
    reg_wr(8'h00, 32'h1);
    seen = 1'b0;
    fork
      feed(4, 1'b1);
      for (int i = 0; i < 200 && !seen; i++) begin
        @(negedge clk);
        seen = burst_wr;
      end
    join
    chk("rst_mid_burst_seen", 64'(seen), 64'd1);
    @(posedge clk); #1; burst_data_req = 1'b1;
    @(posedge clk); #1; burst_data_req = 1'b0;
    #2; reset_n = 1'b0;
    #1;
    chk("midrst_burst_wr", 64'(burst_wr), 64'd0);
    chk("midrst_burst_addr", 64'(burst_addr), 64'd0);
    chk("midrst_burst_len", 64'(burst_len), 64'd0);
    chk("midrst_wr_data", 64'(burst_wr_data), 64'd0);
    chk("midrst_res_ready", 64'(res_ready), 64'd0);
    chk("midrst_reg_ready", 64'(reg_ready), 64'd0);
    @(negedge clk); reset_n = 1'b1;
    exp_data.delete(); exp_baddr.delete(); exp_blen.delete();
    reg_rd(8'h00, v); chk("midrst_status", 64'(v), 64'h2);
    sdram_en = 1'b1;
    run_job("after_rst", 3, 24'h000400, 32'h0, 16, 1'b0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    errors++;
    $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1, "timeout");
  end
endmodule
